// File: rtl/qc_circulant_row_gen_pkg.sv
// ldpc_pkg: shared constants, types and helpers for the QC circulant row
// generator.
//   clog2       - ceiling log2, usable in parameter/localparam expressions
//   ROT_LEFT_C  - rotate-left direction selector (bit i -> bit (i+1) mod Z)
//   ROT_RIGHT_C - rotate-right direction selector
//   Z_DEFAULT   - default circulant size
//   state_t     - generator FSM state encoding
package ldpc_pkg;

  localparam int ROT_LEFT_C  = 1;
  localparam int ROT_RIGHT_C = 0;
  localparam int Z_DEFAULT   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qc_circulant_row_gen_if.sv
// Handshake bundle for qc_circulant_row_gen.
//   Load side : in_valid, in_ready, in_data[Z], in_offset[CW]
//   Row side  : out_valid, out_ready, out_data[Z], out_row[CW], out_last
// master = the block feeding loads and consuming rows; slave = the generator.
interface qc_circulant_row_gen_if
  import ldpc_pkg::*;
#(
  parameter int Z = Z_DEFAULT
) ();

  localparam int CW = clog2(Z);

  logic          in_valid;
  logic          in_ready;
  logic [Z-1:0]  in_data;
  logic [CW-1:0] in_offset;
  logic          out_valid;
  logic          out_ready;
  logic [Z-1:0]  out_data;
  logic [CW-1:0] out_row;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_offset, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  in_valid, in_data, in_offset, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );

endinterface

// File: rtl/qc_circulant_row_gen_barrel_rotator.sv
// barrel_rotator: combinational circular rotate of a Z-bit word by a CW-bit
// amount (amount must be < Z).
//   d   - input word
//   amt - rotate amount
//   q   - rotated word, direction selected by ROT_LEFT
// Built as log2 stages; stage k rotates by (2^k mod Z), so the stage amounts
// sum to amt and non-power-of-two Z works without a modulo on the datapath.
module barrel_rotator
  import ldpc_pkg::*;
#(
  parameter int Z        = Z_DEFAULT,
  parameter int ROT_LEFT = ROT_LEFT_C,
  localparam int CW      = clog2(Z)
) (
  input  logic [Z-1:0]  d,
  input  logic [CW-1:0] amt,
  output logic [Z-1:0]  q
);

  logic [Z-1:0] stage [0:CW];
  logic [Z-1:0] shifted [0:CW-1];

  assign stage[0] = d;

  for (genvar k = 0; k < CW; k++) begin : g_stage
    localparam int S = (1 << k) % Z;
    for (genvar i = 0; i < Z; i++) begin : g_bit
      localparam int DST = (ROT_LEFT != 0) ? ((i + S) % Z) : ((i + Z - S) % Z);
      assign shifted[k][DST] = stage[k][i];
    end
    assign stage[k+1] = amt[k] ? shifted[k] : stage[k];
  end

  assign q = stage[CW];

endmodule

// File: rtl/qc_circulant_row_gen.sv
// qc_circulant_row_gen: emits NUM_ROWS consecutive rows of a quasi-cyclic
// circulant block. A load captures a base row pre-rotated by the circulant
// offset; each accepted beat rotates the row by one position.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of qc_circulant_row_gen_if (load and row handshakes)
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no burst active, out_valid=0, ready for a load
// ST_RUN  | row register valid, advancing on each accepted beat
module qc_circulant_row_gen
  import ldpc_pkg::*;
#(
  parameter int Z        = Z_DEFAULT,
  parameter int ROT_LEFT = ROT_LEFT_C,
  parameter int NUM_ROWS = Z
) (
  input  logic                clk,
  input  logic                rst_n,
  qc_circulant_row_gen_if.slave bus
);

  localparam int CW = clog2(Z);
  localparam logic [CW-1:0] LAST_ROW = CW'(NUM_ROWS - 1);

  state_t        state;
  logic [Z-1:0]  row_q;
  logic [CW-1:0] row_idx;

  logic          valid_w;
  logic          last_w;
  logic          ready_w;
  logic          load;
  logic          beat;
  logic [CW-1:0] eff_offset;
  logic [Z-1:0]  load_row;
  logic [Z-1:0]  next_row;

  assign valid_w = (state == ST_RUN);
  assign last_w  = valid_w && (row_idx == LAST_ROW);
  // A last beat frees the register in the same cycle, so a new burst can
  // follow without a bubble.
  assign ready_w = (state == ST_IDLE) || (valid_w && bus.out_ready && last_w);
  assign load    = bus.in_valid && ready_w;
  assign beat    = valid_w && bus.out_ready;

  // Offsets in [Z, 2^CW) fold back by one circulant period.
  always_comb begin
    eff_offset = bus.in_offset;
    if ({1'b0, bus.in_offset} >= (CW+1)'(Z)) eff_offset = bus.in_offset - CW'(Z);
  end

  barrel_rotator #(
    .Z        (Z),
    .ROT_LEFT (ROT_LEFT)
  ) u_rot (
    .d   (bus.in_data),
    .amt (eff_offset),
    .q   (load_row)
  );

  if (ROT_LEFT != 0) begin : g_step_left
    assign next_row = {row_q[Z-2:0], row_q[Z-1]};
  end else begin : g_step_right
    assign next_row = {row_q[0], row_q[Z-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row_q   <= '0;
      row_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            row_q   <= load_row;
            row_idx <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load) begin
            row_q   <= load_row;
            row_idx <= '0;
          end else if (beat) begin
            if (last_w) begin
              state <= ST_IDLE;
            end else begin
              row_q   <= next_row;
              row_idx <= row_idx + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_w;
  assign bus.out_valid = valid_w;
  assign bus.out_data  = row_q;
  assign bus.out_row   = row_idx;
  assign bus.out_last  = last_w;

endmodule

// File: tb/tb_qc_circulant_row_gen.sv
module tb_qc_circulant_row_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qc_circulant_row_gen_if #(.Z(16)) if_a ();
  qc_circulant_row_gen_if #(.Z(16)) if_b ();
  qc_circulant_row_gen_if #(.Z(12)) if_c ();
  qc_circulant_row_gen_if #(.Z(16)) if_d ();

  qc_circulant_row_gen #(.Z(16), .ROT_LEFT(1), .NUM_ROWS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  qc_circulant_row_gen #(.Z(16), .ROT_LEFT(0), .NUM_ROWS(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  qc_circulant_row_gen #(.Z(12), .ROT_LEFT(1), .NUM_ROWS(12)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  qc_circulant_row_gen #(.Z(16), .ROT_LEFT(1), .NUM_ROWS(4))  dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] e16;
    logic [11:0] e12;

    if_a.in_valid = 0; if_a.in_data = '0; if_a.in_offset = '0; if_a.out_ready = 1;
    if_b.in_valid = 0; if_b.in_data = '0; if_b.in_offset = '0; if_b.out_ready = 1;
    if_c.in_valid = 0; if_c.in_data = '0; if_c.in_offset = '0; if_c.out_ready = 1;
    if_d.in_valid = 0; if_d.in_data = '0; if_d.in_offset = '0; if_d.out_ready = 1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_ready", 32'(if_a.in_ready), 32'd1);
    chk("rst_data", 32'(if_a.out_data), 32'h0);
    chk("rst_row", 32'(if_a.out_row), 32'd0);
    chk("rst_last", 32'(if_a.out_last), 32'd0);
    rst_n = 1;
    @(negedge clk);

    // basic burst, rotate left
    if_a.in_valid = 1; if_a.in_data = 16'h0001; if_a.in_offset = 4'd0;
    @(negedge clk);
    if_a.in_valid = 0;
    for (int r = 0; r < 16; r++) begin
      e16 = 16'h0001 << r;
      chk("a_valid", 32'(if_a.out_valid), 32'd1);
      chk("a_data", 32'(if_a.out_data), 32'(e16));
      chk("a_row", 32'(if_a.out_row), 32'(r));
      chk("a_last", 32'(if_a.out_last), (r == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("a_idle_valid", 32'(if_a.out_valid), 32'd0);
    chk("a_idle_ready", 32'(if_a.in_ready), 32'd1);

    // load offset, rotate right
    if_b.in_valid = 1; if_b.in_data = 16'h0001; if_b.in_offset = 4'd3;
    @(negedge clk);
    if_b.in_valid = 0;
    for (int r = 0; r < 16; r++) begin
      e16 = 16'h0001 << ((13 - r + 16) % 16);
      chk("b_data", 32'(if_b.out_data), 32'(e16));
      chk("b_last", 32'(if_b.out_last), (r == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("b_idle", 32'(if_b.out_valid), 32'd0);

    // offset reduction, Z=12, offset 13 behaves as offset 1
    if_c.in_valid = 1; if_c.in_data = 12'h001; if_c.in_offset = 4'd13;
    @(negedge clk);
    if_c.in_valid = 0;
    for (int r = 0; r < 12; r++) begin
      e12 = 12'h001 << ((1 + r) % 12);
      chk("c_data", 32'(if_c.out_data), 32'(e12));
      chk("c_row", 32'(if_c.out_row), 32'(r));
      chk("c_last", 32'(if_c.out_last), (r == 11) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("c_idle", 32'(if_c.out_valid), 32'd0);
    if_c.in_valid = 1; if_c.in_data = 12'h001; if_c.in_offset = 4'd1;
    @(negedge clk);
    if_c.in_valid = 0;
    chk("c_off1_data", 32'(if_c.out_data), 32'h002);
    if_c.in_valid = 1; if_c.in_data = 12'h001; if_c.in_offset = 4'd12;
    if_c.out_ready = 0;
    @(negedge clk);
    chk("c_busy_ignored", 32'(if_c.out_data), 32'h002);
    if_c.in_valid = 0; if_c.out_ready = 1;

    // backpressure at row 5
    if_a.in_valid = 1; if_a.in_data = 16'h0001; if_a.in_offset = 4'd0;
    @(negedge clk);
    if_a.in_valid = 0;
    for (int r = 0; r < 16; r++) begin
      e16 = 16'h0001 << r;
      chk("bp_data", 32'(if_a.out_data), 32'(e16));
      chk("bp_row", 32'(if_a.out_row), 32'(r));
      if (r == 5) begin
        if_a.out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data", 32'(if_a.out_data), 32'h0020);
          chk("bp_hold_row", 32'(if_a.out_row), 32'd5);
          chk("bp_hold_last", 32'(if_a.out_last), 32'd0);
        end
        if_a.out_ready = 1;
      end
      @(negedge clk);
    end
    chk("bp_idle", 32'(if_a.out_valid), 32'd0);

    // back-to-back loads, NUM_ROWS=4
    if_d.in_valid = 1; if_d.in_data = 16'h0001; if_d.in_offset = 4'd0;
    @(negedge clk);
    if_d.in_valid = 0;
    chk("d_r0", 32'(if_d.out_data), 32'h0001);
    #1 chk("d_ready_mid", 32'(if_d.in_ready), 32'd0);
    @(negedge clk);
    // load attempt while busy must be ignored
    if_d.in_valid = 1; if_d.in_data = 16'hAAAA; if_d.in_offset = 4'd5;
    chk("d_r1", 32'(if_d.out_data), 32'h0002);
    @(negedge clk);
    if_d.in_valid = 0;
    chk("d_r2", 32'(if_d.out_data), 32'h0004);
    chk("d_r2_row", 32'(if_d.out_row), 32'd2);
    @(negedge clk);
    chk("d_r3", 32'(if_d.out_data), 32'h0008);
    chk("d_r3_last", 32'(if_d.out_last), 32'd1);
    if_d.out_ready = 0;
    #1 chk("d_ready_stalled_last", 32'(if_d.in_ready), 32'd0);
    if_d.out_ready = 1;
    if_d.in_valid = 1; if_d.in_data = 16'h0100; if_d.in_offset = 4'd0;
    #1 chk("d_ready_last", 32'(if_d.in_ready), 32'd1);
    @(negedge clk);
    if_d.in_valid = 0;
    chk("d_b2_valid", 32'(if_d.out_valid), 32'd1);
    chk("d_b2_data", 32'(if_d.out_data), 32'h0100);
    chk("d_b2_row", 32'(if_d.out_row), 32'd0);
    for (int r = 1; r < 4; r++) begin
      @(negedge clk);
      e16 = 16'h0100 << r;
      chk("d_b2_rows", 32'(if_d.out_data), 32'(e16));
    end
    chk("d_b2_last", 32'(if_d.out_last), 32'd1);
    @(negedge clk);
    chk("d_idle", 32'(if_d.out_valid), 32'd0);

    // reset mid-burst at row 7
    if_a.in_valid = 1; if_a.in_data = 16'h0001; if_a.in_offset = 4'd0;
    @(negedge clk);
    if_a.in_valid = 0;
    repeat (7) @(negedge clk);
    chk("rm_row7", 32'(if_a.out_row), 32'd7);
    rst_n = 0;
    @(negedge clk);
    chk("rm_valid", 32'(if_a.out_valid), 32'd0);
    chk("rm_data", 32'(if_a.out_data), 32'h0000);
    chk("rm_ready", 32'(if_a.in_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);
    chk("rm_post_idle", 32'(if_a.out_valid), 32'd0);
    if_a.in_valid = 1; if_a.in_data = 16'h8000; if_a.in_offset = 4'd1;
    @(negedge clk);
    if_a.in_valid = 0;
    chk("rm_new_r0", 32'(if_a.out_data), 32'h0001);
    chk("rm_new_row", 32'(if_a.out_row), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
